// File: rtl/pong_game_sequencer_if.sv
// Button/event inputs and game-status outputs shared between the pong
// game sequencer and whatever drives it (button logic, ball datapath, overlay).
interface pong_game_sequencer_if;
  logic        startbutton;
  logic        pausebutton;
  logic        hit;
  logic        miss;
  logic        ballload;
  logic        step;
  logic        paddleen;
  logic [15:0] score;
  logic [1:0]  lives;
  logic        gameover;
  logic [2:0]  state;

  modport master (
    output startbutton, pausebutton, hit, miss,
    input  ballload, step, paddleen, score, lives, gameover, state
  );

  modport slave (
    input  startbutton, pausebutton, hit, miss,
    output ballload, step, paddleen, score, lives, gameover, state
  );
endinterface

// File: rtl/pong_game_sequencer.sv
// Game-level controller for single-player pong: physics step prescaler,
// serve/play/pause/life-lost/game-over sequencing, BCD score and lives.
module pong_game_sequencer #(
  parameter int STEP_DIV    = 833333,
  parameter int SERVE_STEPS = 60,
  parameter int LIVES       = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  pong_game_sequencer_if.slave  bus
);

  localparam int CW = $clog2(STEP_DIV);
  localparam int SW = (SERVE_STEPS > 1) ? $clog2(SERVE_STEPS) : 1;
  localparam logic [CW-1:0] TICK_AT    = CW'(STEP_DIV - 1);
  localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_STEPS - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_LOST  = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_serveCnt;
  logic          r_startPrev;
  logic          r_pausePrev;
  logic          r_ballload;
  logic          r_step;
  logic          r_paddleen;
  logic          r_gameover;
  logic [15:0]   r_score;
  logic [1:0]    r_lives;

  logic w_tick;
  logic w_startEdge;
  logic w_pauseEdge;

  assign w_tick      = (r_count == TICK_AT);
  assign w_startEdge = bus.startbutton & ~r_startPrev;
  assign w_pauseEdge = bus.pausebutton & ~r_pausePrev;

  // Decimal increment with digit carry, holding at 9999.
  function automatic logic [15:0] bcdInc(input logic [15:0] v);
    logic [15:0] res;
    logic        carry;
    res   = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int d = 0; d < 4; d++) begin
        if (carry) begin
          if (v[d*4 +: 4] >= 4'd9) begin
            res[d*4 +: 4] = 4'd0;
          end else begin
            res[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    return res;
  endfunction

  // Prev registers come out of reset high so a button held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_startPrev <= 1'b1;
      r_pausePrev <= 1'b1;
      r_count     <= '0;
    end else begin
      r_startPrev <= bus.startbutton;
      r_pausePrev <= bus.pausebutton;
      r_count     <= w_tick ? '0 : r_count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_score    <= 16'h0000;
      r_lives    <= LIVES_INIT;
      r_serveCnt <= '0;
      r_ballload <= 1'b0;
      r_step     <= 1'b0;
      r_paddleen <= 1'b0;
      r_gameover <= 1'b0;
    end else begin
      r_ballload <= 1'b0;
      r_step     <= 1'b0;
      case (r_state)
        S_IDLE, S_OVER: begin
          if (w_startEdge) begin
            r_state    <= S_SERVE;
            r_score    <= 16'h0000;
            r_lives    <= LIVES_INIT;
            r_serveCnt <= '0;
            r_ballload <= 1'b1;
            r_paddleen <= 1'b1;
            r_gameover <= 1'b0;
          end
        end
        S_SERVE: begin
          if (w_tick) begin
            if (r_serveCnt == SERVE_LAST) r_state <= S_PLAY;
            else r_serveCnt <= r_serveCnt + SW'(1);
          end
        end
        // Event priority in play: miss, then pause edge, then hit.
        S_PLAY: begin
          if (bus.miss) begin
            r_paddleen <= 1'b0;
            if (r_lives > 2'd1) begin
              r_lives <= r_lives - 2'd1;
              r_state <= S_LOST;
            end else begin
              r_lives    <= 2'd0;
              r_state    <= S_OVER;
              r_gameover <= 1'b1;
            end
          end else if (w_pauseEdge) begin
            r_state    <= S_PAUSE;
            r_paddleen <= 1'b0;
          end else begin
            if (bus.hit) r_score <= bcdInc(r_score);
            if (w_tick)  r_step  <= 1'b1;
          end
        end
        S_PAUSE: begin
          if (w_pauseEdge) begin
            r_state    <= S_PLAY;
            r_paddleen <= 1'b1;
          end
        end
        S_LOST: begin
          if (w_tick) begin
            r_state    <= S_SERVE;
            r_serveCnt <= '0;
            r_ballload <= 1'b1;
            r_paddleen <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_paddleen <= 1'b0;
          r_gameover <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ballload = r_ballload;
  assign bus.step     = r_step;
  assign bus.paddleen = r_paddleen;
  assign bus.score    = r_score;
  assign bus.lives    = r_lives;
  assign bus.gameover = r_gameover;
  assign bus.state    = r_state;

endmodule
